// File: rtl/dot_product_sequencer_pkg.sv
// Shared types and constants for the dot-product sequencer and its FP unit.
package dot_product_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCUM,
        ST_DONE
    } state_t;

    // Bit positions within the 5-bit exception vector.
    localparam int unsigned EXC_INVALID   = 4;
    localparam int unsigned EXC_INFINITE  = 3;
    localparam int unsigned EXC_OVERFLOW  = 2;
    localparam int unsigned EXC_UNDERFLOW = 1;
    localparam int unsigned EXC_INEXACT   = 0;

    // Rounding-mode encodings.
    localparam logic [2:0] RM_RNE = 3'd0;  // nearest, ties to even
    localparam logic [2:0] RM_RTZ = 3'd1;  // toward zero
    localparam logic [2:0] RM_RDN = 3'd2;  // toward -inf
    localparam logic [2:0] RM_RUP = 3'd3;  // toward +inf
    localparam logic [2:0] RM_RMM = 3'd4;  // nearest, ties away from zero

    // The value 1.0: sign 0, exponent = bias (MSB 0, rest 1), significand 0.
    function automatic logic [63:0] fp_one(input int unsigned e_w, input int unsigned m_w);
        logic [63:0] v;
        v = ((64'd1 << (e_w - 1)) - 64'd1) << (m_w - 1);
        return v;
    endfunction

endpackage

// File: rtl/matrix_multiply_1x2_2x1.sv
// Combinational c1 = a11*b1 + a12*b2 with a single rounding step.
module matrix_multiply_1x2_2x1
    import dot_product_sequencer_pkg::*;
#(
    parameter int unsigned exp_width  = 8,
    parameter int unsigned mant_width = 24
) (
    input  logic [exp_width+mant_width-1:0] a11,
    input  logic [exp_width+mant_width-1:0] a12,
    input  logic [exp_width+mant_width-1:0] b1,
    input  logic [exp_width+mant_width-1:0] b2,
    input  logic [2:0]                      round_mode,
    output logic [exp_width+mant_width-1:0] c1,
    output logic [4:0]                      exceptions
);

    localparam int unsigned E  = exp_width;
    localparam int unsigned M  = mant_width;
    localparam int unsigned F  = M - 1;
    localparam int unsigned DW = E + M;
    localparam int unsigned PW = 2 * M;
    // Sum frame: carry bit, normalised product, then 2M+2 bits of alignment room.
    localparam int unsigned FW = 4 * M + 3;

    typedef logic signed [31:0] sexp_t;

    localparam sexp_t BIAS = sexp_t'((1 << (E - 1)) - 1);
    localparam sexp_t EMAX = sexp_t'((1 << E) - 1);

    function automatic sexp_t eff_exp(input logic [E-1:0] e);
        return (e == '0) ? sexp_t'(1) : sexp_t'(e);
    endfunction

    function automatic sexp_t lzc_pw(input logic [PW-1:0] v);
        sexp_t n;
        n = sexp_t'(PW);
        for (int unsigned i = 0; i < PW; i++)
            if (v[i]) n = sexp_t'(PW - 1 - i);
        return n;
    endfunction

    function automatic sexp_t lzc_fw(input logic [FW-1:0] v);
        sexp_t n;
        n = sexp_t'(FW);
        for (int unsigned i = 0; i < FW; i++)
            if (v[i]) n = sexp_t'(FW - 1 - i);
        return n;
    endfunction

    logic [DW-1:0] opnd    [4];
    logic          op_s    [4];
    logic [E-1:0]  op_e    [4];
    logic [M-1:0]  op_sig  [4];
    logic          op_zero [4];
    logic          op_inf  [4];
    logic          op_nan  [4];
    logic          op_snan [4];

    logic          p_s    [2];
    logic [PW-1:0] p_sig  [2];
    sexp_t         p_exp  [2];
    logic          p_zero [2];
    logic          p_inf  [2];
    logic          p_inv  [2];

    logic [FW-1:0] sum;
    logic          sum_s;
    sexp_t         sum_exp;

    assign opnd[0] = a11;
    assign opnd[1] = b1;
    assign opnd[2] = a12;
    assign opnd[3] = b2;

    // Split every operand into sign, exponent, significand and class flags.
    always_comb begin
        for (int unsigned i = 0; i < 4; i++) begin
            op_s[i]    = opnd[i][DW-1];
            op_e[i]    = opnd[i][DW-2 -: E];
            op_sig[i]  = {op_e[i] != '0, opnd[i][F-1:0]};
            op_zero[i] = (op_e[i] == '0) && (opnd[i][F-1:0] == '0);
            op_inf[i]  = (op_e[i] == '1) && (opnd[i][F-1:0] == '0);
            op_nan[i]  = (op_e[i] == '1) && (opnd[i][F-1:0] != '0);
            op_snan[i] = op_nan[i] && !opnd[i][F-1];
        end
    end

    // Exact products, normalised so the leading one sits at bit PW-1.
    always_comb begin
        logic [PW-1:0] raw;
        sexp_t         lz;
        raw = '0;
        lz  = '0;
        for (int unsigned k = 0; k < 2; k++) begin
            raw       = PW'(op_sig[2*k]) * PW'(op_sig[2*k+1]);
            lz        = lzc_pw(raw);
            p_sig[k]  = raw << lz;
            p_exp[k]  = eff_exp(op_e[2*k]) + eff_exp(op_e[2*k+1]) - BIAS - lz;
            p_s[k]    = op_s[2*k] ^ op_s[2*k+1];
            p_zero[k] = (raw == '0);
            p_inf[k]  = (op_inf[2*k] || op_inf[2*k+1]) && !(op_zero[2*k] || op_zero[2*k+1]);
            p_inv[k]  = (op_inf[2*k] && op_zero[2*k+1]) || (op_zero[2*k] && op_inf[2*k+1]);
        end
    end

    // Align the smaller-magnitude product to the larger and add; bits shifted
    // out are jammed into the LSB so rounding still sees them.
    always_comb begin
        logic          first_big;
        logic [PW-1:0] b_sig, s_sig;
        logic          s_s, s_zero;
        sexp_t         d;
        logic [FW-1:0] fb, fs_full, fs;
        first_big = p_zero[1] || (!p_zero[0] && ((p_exp[0] > p_exp[1]) ||
                    ((p_exp[0] == p_exp[1]) && (p_sig[0] >= p_sig[1]))));
        b_sig   = first_big ? p_sig[0] : p_sig[1];
        s_sig   = first_big ? p_sig[1] : p_sig[0];
        sum_s   = first_big ? p_s[0]   : p_s[1];
        s_s     = first_big ? p_s[1]   : p_s[0];
        sum_exp = first_big ? p_exp[0] : p_exp[1];
        s_zero  = first_big ? p_zero[1] : p_zero[0];
        d       = sum_exp - (first_big ? p_exp[1] : p_exp[0]);
        fb      = FW'(b_sig) << (2 * M + 2);
        fs_full = FW'(s_sig) << (2 * M + 2);
        fs      = fs_full >> d;
        fs[0]   = fs[0] | (|(fs_full & ~({FW{1'b1}} << d)));
        if (s_zero) fs = '0;
        sum = (sum_s == s_s) ? fb + fs : fb - fs;
    end

    // Normalise (denormalising when tiny), round, and resolve special values.
    always_comb begin
        sexp_t         lz, re, sh;
        logic [FW-1:0] norm;
        logic          st_r, hid, g, st, inc, to_inf;
        logic [E-1:0]  exp_field;
        logic [F-1:0]  frac;
        logic [DW-2:0] rounded;
        logic          ovf, any_nan, any_snan, inv;
        lz   = lzc_fw(sum);
        re   = sum_exp + 2 - lz;
        sh   = (re < 1) ? lz - (1 - re) : lz;
        norm = '0;
        st_r = 1'b0;
        if (sh >= 0) begin
            norm = sum << sh;
        end else begin
            norm = sum >> (-sh);
            st_r = |(sum & ~({FW{1'b1}} << (-sh)));
        end
        hid       = norm[FW-1];
        frac      = norm[FW-2 -: F];
        g         = norm[FW-2-F];
        st        = (|norm[FW-3-F:0]) | st_r;
        exp_field = (re < 1) ? E'(hid) : re[E-1:0];
        case (round_mode)
            RM_RTZ:  inc = 1'b0;
            RM_RDN:  inc = sum_s & (g | st);
            RM_RUP:  inc = !sum_s & (g | st);
            RM_RMM:  inc = g;
            default: inc = g & (st | frac[0]);
        endcase
        rounded = {exp_field, frac} + (DW-1)'(inc);
        ovf     = (re >= EMAX) || (rounded[DW-2 -: E] == '1);
        case (round_mode)
            RM_RTZ:  to_inf = 1'b0;
            RM_RDN:  to_inf = sum_s;
            RM_RUP:  to_inf = !sum_s;
            default: to_inf = 1'b1;
        endcase

        any_nan  = op_nan[0] | op_nan[1] | op_nan[2] | op_nan[3];
        any_snan = op_snan[0] | op_snan[1] | op_snan[2] | op_snan[3];
        inv      = p_inv[0] | p_inv[1] | (p_inf[0] & p_inf[1] & (p_s[0] != p_s[1]));

        exceptions = '0;
        if (any_nan || inv) begin
            c1 = {1'b0, {E{1'b1}}, 1'b1, {(F-1){1'b0}}};
            exceptions[EXC_INVALID] = any_snan | inv;
        end else if (p_inf[0] || p_inf[1]) begin
            c1 = {p_inf[0] ? p_s[0] : p_s[1], {E{1'b1}}, {F{1'b0}}};
            exceptions[EXC_INFINITE] = 1'b1;
        end else if (sum == '0) begin
            // Exact zero: like-signed zero products keep their sign, else +0 (-0 rounding down).
            if (p_zero[0] && p_zero[1] && (p_s[0] == p_s[1]))
                c1 = {p_s[0], {(DW-1){1'b0}}};
            else
                c1 = {round_mode == RM_RDN, {(DW-1){1'b0}}};
        end else if (ovf) begin
            c1 = to_inf ? {sum_s, {E{1'b1}}, {F{1'b0}}}
                        : {sum_s, {(E-1){1'b1}}, 1'b0, {F{1'b1}}};
            exceptions[EXC_OVERFLOW] = 1'b1;
            exceptions[EXC_INEXACT]  = 1'b1;
        end else begin
            c1 = {sum_s, rounded};
            exceptions[EXC_INEXACT]   = g | st;
            exceptions[EXC_UNDERFLOW] = (re < 1) & (g | st);
        end
    end

endmodule

// File: rtl/dot_product_sequencer.sv
// Streams x/w element pairs through one FP multiply-add, accumulating a dot product.
module dot_product_sequencer
    import dot_product_sequencer_pkg::*;
#(
    parameter int unsigned exp_width  = 8,
    parameter int unsigned mant_width = 24,
    parameter int unsigned MAX_LEN    = 256,
    localparam int unsigned DW    = exp_width + mant_width,
    localparam int unsigned LEN_W = $clog2(MAX_LEN + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic [2:0]       round_mode,
    output logic             busy,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [DW-1:0]    x,
    input  logic [DW-1:0]    w,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [DW-1:0]    result,
    output logic [4:0]       exceptions
);

    localparam logic [DW-1:0] ONE = DW'(fp_one(exp_width, mant_width));

    state_t           state, state_n;
    logic [DW-1:0]    acc, acc_n;
    logic [4:0]       exc, exc_n;
    logic [LEN_W-1:0] count, count_n;
    logic [LEN_W-1:0] len_q, len_n;
    logic [2:0]       rm_q, rm_n;
    logic [DW-1:0]    unit_c1;
    logic [4:0]       unit_exc;

    // acc*ONE term lets the 1x2*2x1 unit act as a fused x*w + acc.
    matrix_multiply_1x2_2x1 #(
        .exp_width (exp_width),
        .mant_width(mant_width)
    ) u_mac (
        .a11       (x),
        .a12       (acc),
        .b1        (w),
        .b2        (ONE),
        .round_mode(rm_q),
        .c1        (unit_c1),
        .exceptions(unit_exc)
    );

    // State and accumulator registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            acc   <= '0;
            exc   <= '0;
            count <= '0;
            len_q <= '0;
            rm_q  <= '0;
        end else begin
            state <= state_n;
            acc   <= acc_n;
            exc   <= exc_n;
            count <= count_n;
            len_q <= len_n;
            rm_q  <= rm_n;
        end
    end

    // Next-state, datapath update and handshake outputs.
    always_comb begin
        state_n   = state;
        acc_n     = acc;
        exc_n     = exc;
        count_n   = count;
        len_n     = len_q;
        rm_n      = rm_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    len_n   = len;
                    rm_n    = round_mode;
                    acc_n   = '0;
                    exc_n   = '0;
                    count_n = '0;
                    state_n = (len != '0) ? ST_ACCUM : ST_DONE;
                end
            end
            ST_ACCUM: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    acc_n   = unit_c1;
                    exc_n   = exc | unit_exc;
                    count_n = count + LEN_W'(1);
                    if (count_n == len_q) state_n = ST_DONE;
                end
            end
            ST_DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_n = ST_IDLE;
            end
            default: state_n = ST_IDLE;
        endcase
        busy       = (state != ST_IDLE);
        result     = acc;
        exceptions = exc;
    end

endmodule

// File: tb/tb_dot_product_sequencer.sv
// Directed scoreboard bench for dot_product_sequencer at default FP32 widths.
module tb_dot_product_sequencer;

    localparam int unsigned LW = 9;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [LW-1:0] len = '0;
    logic [2:0]    round_mode = '0;
    logic          busy, in_ready, out_valid;
    logic          in_valid = 1'b0;
    logic          out_ready = 1'b0;
    logic [31:0]   x = '0;
    logic [31:0]   w = '0;
    logic [31:0]   result;
    logic [4:0]    exceptions;

    typedef struct packed {
        logic [31:0] res;
        logic [4:0]  exc;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          passes = 0;
    logic [31:0] xs [256];
    logic [31:0] ws [256];

    dot_product_sequencer #(
        .exp_width (8),
        .mant_width(24),
        .MAX_LEN   (256)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .len       (len),
        .round_mode(round_mode),
        .busy      (busy),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x         (x),
        .w         (w),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .exceptions(exceptions)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) passes++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One operation: start, feed n pairs (with gap idle cycles before each),
    // optionally pulse start again at element restart_at, stall the result.
    task automatic run_op(input string tag, input int n, input logic [2:0] rm,
                          input int gap, input int stall, input int restart_at,
                          input logic [31:0] exp_res, input logic [4:0] exp_exc);
        exp_t e;
        sb.push_back({exp_res, exp_exc});
        chk({tag, "_idle_ovalid"}, out_valid, 0);
        start = 1'b1;
        len = LW'(n);
        round_mode = rm;
        step();
        start = 1'b0;
        for (int i = 0; i < n; i++) begin
            for (int g = 0; g < gap; g++) begin
                in_valid = 1'b0;
                chk({tag, "_gap_ready"}, in_ready, 1);
                step();
            end
            in_valid = 1'b1;
            x = xs[i];
            w = ws[i];
            if (i == restart_at) begin
                start = 1'b1;
                len = LW'(5);
            end
            if (i == 0 || i == n - 1) begin
                chk({tag, "_accum_ready"}, in_ready, 1);
                chk({tag, "_accum_ovalid"}, out_valid, 0);
            end
            step();
            start = 1'b0;
        end
        in_valid = 1'b0;
        chk({tag, "_out_valid"}, out_valid, 1);
        chk({tag, "_done_ready"}, in_ready, 0);
        for (int s = 0; s < stall; s++) begin
            chk({tag, "_stall_result"}, result, sb[0].res);
            chk({tag, "_stall_valid"}, out_valid, 1);
            step();
        end
        out_ready = 1'b1;
        e = sb.pop_front();
        chk({tag, "_result"}, result, e.res);
        chk({tag, "_exc"}, exceptions, e.exc);
        step();
        out_ready = 1'b0;
        chk({tag, "_idle_busy"}, busy, 0);
    endtask

    initial begin
        rst_n = 1'b0;
        step();
        step();
        chk("rst_busy", busy, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_result", result, 0);
        chk("rst_exc", exceptions, 0);
        rst_n = 1'b1;
        step();

        xs[0] = 32'h40000000; ws[0] = 32'h3f800000;
        xs[1] = 32'h3fc00000; ws[1] = 32'h40000000;
        run_op("dot2", 2, 3'd0, 0, 0, -1, 32'h40a00000, 5'b00000);

        run_op("len0", 0, 3'd0, 0, 0, -1, 32'h00000000, 5'b00000);

        xs[0] = 32'h3f800000; ws[0] = 32'h40000000;
        xs[1] = 32'h40000000; ws[1] = 32'h40000000;
        xs[2] = 32'h40400000; ws[2] = 32'h3f000000;
        run_op("len3", 3, 3'd0, 0, 0, -1, 32'h40f00000, 5'b00000);
        run_op("len3_gaps", 3, 3'd0, 2, 3, -1, 32'h40f00000, 5'b00000);

        xs[0] = 32'h7f7fffff; ws[0] = 32'h40000000;
        run_op("ovf_rne", 1, 3'd0, 0, 0, -1, 32'h7f800000, 5'b00101);
        run_op("ovf_rtz", 1, 3'd1, 0, 0, -1, 32'h7f7fffff, 5'b00101);

        xs[0] = 32'hc0000000; ws[0] = 32'h40400000;
        xs[1] = 32'h40800000; ws[1] = 32'h3f800000;
        run_op("cancel", 2, 3'd0, 0, 0, -1, 32'hc0000000, 5'b00000);

        // Abort mid-accumulation with reset; nothing is expected from it.
        start = 1'b1;
        len = LW'(3);
        step();
        start = 1'b0;
        in_valid = 1'b1;
        x = 32'h40400000;
        w = 32'h3f800000;
        step();
        in_valid = 1'b0;
        chk("pre_rst_busy", busy, 1);
        rst_n = 1'b0;
        step();
        chk("midrst_busy", busy, 0);
        chk("midrst_in_ready", in_ready, 0);
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_result", result, 0);
        rst_n = 1'b1;
        step();
        xs[0] = 32'h40400000; ws[0] = 32'h3f800000;
        run_op("after_rst", 1, 3'd0, 0, 0, -1, 32'h40400000, 5'b00000);

        xs[0] = 32'h40000000; ws[0] = 32'h3f800000;
        xs[1] = 32'h3fc00000; ws[1] = 32'h40000000;
        run_op("restart_ignored", 2, 3'd0, 0, 0, 0, 32'h40a00000, 5'b00000);

        for (int i = 0; i < 256; i++) begin
            xs[i] = 32'h3f800000;
            ws[i] = 32'h3f800000;
        end
        run_op("maxlen", 256, 3'd0, 0, 0, -1, 32'h43800000, 5'b00000);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/dot_product_sequencer.md
DOT_PRODUCT_SEQUENCER -- requirements
Module: dot_product_sequencer

Interface
REQ-001 SHALL have parameter exp_width, default 8, FP exponent width.
REQ-002 SHALL have parameter mant_width, default 24, FP significand width; data width DW = exp_width+mant_width.
REQ-003 SHALL have parameter MAX_LEN, default 256, maximum vector length; LEN_W = $clog2(MAX_LEN+1).
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 rst_n  input  1  reset, synchronous, active-low.
REQ-006 start  input  1  begin a dot product; sampled only in IDLE.
REQ-007 len  input  LEN_W  element count; sampled with start.
REQ-008 round_mode  input  3  rounding mode; sampled with start.
REQ-009 busy  output  1  high in any state other than IDLE.
REQ-010 in_valid  input  1  element pair x/w present.
REQ-011 in_ready  output  1  sequencer accepts element pair.
REQ-012 x  input  DW  input-vector element.
REQ-013 w  input  DW  weight element.
REQ-014 out_valid  output  1  result and exceptions valid.
REQ-015 out_ready  input  1  consumer accepts result.
REQ-016 result  output  DW  accumulated dot product.
REQ-017 exceptions  output  5  sticky OR of unit flags {invalid, infinite, overflow, underflow, inexact}.

Function
REQ-018 SHALL drive one shared matrix_multiply_1x2_2x1 per element with a11=x, b1=w, a12=acc, b2=ONE, and round_mode = the latched value, so each step computes acc <= x*w + acc.
REQ-019 SHALL implement FSM IDLE, ACCUM, DONE.
REQ-020 IDLE: start=1 latches len and round_mode, clears acc to +0 (all zeros) and the exception register, and clears the element count; next state is ACCUM if len>0, else DONE.
REQ-021 ACCUM: in_ready=1; each cycle with in_valid=1, acc <= c1, exc <= exc | unit exceptions, count++; the transfer that accepts element number len moves the FSM to DONE.
REQ-022 ACCUM with in_valid=0 SHALL hold acc, exc and count unchanged (gaps allowed).
REQ-023 DONE: out_valid=1, result=acc, exceptions=exc, in_ready=0; outputs SHALL hold stable until out_ready=1, then next state is IDLE.
REQ-024 start in ACCUM or DONE SHALL be ignored.
REQ-025 Throughput: one element per cycle. With in_valid held high, start in cycle 0 SHALL give out_valid in cycle len+1.
REQ-026 in_ready SHALL be 0 in IDLE and DONE. out_valid SHALL be 0 in IDLE and ACCUM.
REQ-027 len > MAX_LEN cannot be represented; len=MAX_LEN SHALL complete normally with no count wrap.

Reset
REQ-028 rst_n=0 at a clock edge SHALL force IDLE, acc=0, exc=0, count=0, and discard any operation in progress, including mid-ACCUM or DONE.
REQ-029 Output values during and after reset: busy=0, in_ready=0, out_valid=0, result=0, exceptions=0.

Structure
REQ-030 A shared package SHALL hold the FSM state enum, the exception bit-index constants and the ONE constant (sign 0, exponent MSB 0 with the remaining exponent bits 1, significand 0; 32'h3f800000 at default widths).
REQ-031 The single sub-module SHALL be matrix_multiply_1x2_2x1, instantiated with exp_width and mant_width passed through.

Verification
REQ-032 len=2, x={40000000,3fc00000}, w={3f800000,40000000}, in_valid held high -> result 40a00000, exceptions 00000, out_valid in cycle 3.
REQ-033 len=0 -> out_valid the cycle after start, result 00000000, exceptions 00000, no in_ready pulse.
REQ-034 len=3 with in_valid gaps of 2 cycles and out_ready low for 3 cycles in DONE -> same result as without gaps; result stable while stalled; in_ready=0 in DONE.
REQ-035 len=1, x=7f7fffff, w=40000000 -> result 7f800000, overflow and inexact exceptions set (00101).
REQ-036 len=3, rst_n low for 1 cycle after the first element is accepted -> busy/in_ready/out_valid=0; then start len=1, x=40400000, w=3f800000 -> result 40400000.
REQ-037 start pulse during ACCUM with len=5 -> ignored; the original len=2 operation completes with the correct result.
